// File: rtl/ikaopll_wrqueue_pkg.sv
// Shared types and default timing for the OPLL host write queue.
// All timing constants are counted in phiM clock enables.
package ikaopll_wrqueue_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAstb,
    StAwait,
    StDstb,
    StDwait
  } seq_state_e;

  localparam int unsigned DefDepth    = 16;
  localparam int unsigned DefStbLen   = 4;
  localparam int unsigned DefAddrWait = 12;
  localparam int unsigned DefDataWait = 84;
  localparam int unsigned CntW        = 7;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } wr_entry_t;

endpackage

// File: rtl/ikaopll_wrqueue_fifo.sv
// Single-clock FIFO of register/data pairs with occupancy and registered not-full.
// Synchronous active-high reset flushes the pointers and the level.
module ikaopll_wrqueue_fifo
  import ikaopll_wrqueue_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  wr_entry_t                wdata_i,
  input  logic                     pop_i,
  output wr_entry_t                rdata_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     not_full_o
);

  localparam int unsigned Aw = $clog2(Depth);
  localparam int unsigned Lw = Aw + 1;

  wr_entry_t         mem_q [Depth];
  logic [Aw-1:0]     wptr_q, rptr_q;
  logic [Lw-1:0]     level_q, level_d;
  logic              not_full_q;
  logic              push_ok, pop_ok;

  // Guard locally too, so a caller that ignores not_full can never corrupt the queue.
  assign push_ok = push_i & not_full_q;
  assign pop_ok  = pop_i & (level_q != '0);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + Lw'(1);
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - Lw'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      not_full_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + Aw'(1);
      if (pop_ok)  rptr_q <= rptr_q + Aw'(1);
      level_q    <= level_d;
      not_full_q <= (level_d != Lw'(Depth));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o    = mem_q[rptr_q];
  assign level_o    = level_q;
  assign not_full_o = not_full_q;

endmodule

// File: rtl/ikaopll_wrqueue.sv
// Host write queue and bus sequencer feeding the OPLL CPU port: each queued pair
// is replayed as an address strobe, a wait, a data strobe and a wait, paced by phiM enables.
module ikaopll_wrqueue
  import ikaopll_wrqueue_pkg::*;
#(
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned STB_LEN   = DefStbLen,
  parameter int unsigned ADDR_WAIT = DefAddrWait,
  parameter int unsigned DATA_WAIT = DefDataWait
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_RST,
  input  logic                     i_phiM_PCEN_n,
  input  logic                     i_WR_VALID,
  output logic                     o_WR_READY,
  input  logic [7:0]               i_WR_REG,
  input  logic [7:0]               i_WR_DATA,
  output logic                     o_CS_n,
  output logic                     o_WR_n,
  output logic                     o_A0,
  output logic [7:0]               o_D,
  output logic [$clog2(DEPTH):0]   o_LEVEL,
  output logic                     o_BUSY,
  output logic                     o_OVF
);

  localparam logic [CntW-1:0] StbLoad  = CntW'(STB_LEN - 1);
  localparam logic [CntW-1:0] AddrLoad = CntW'(ADDR_WAIT - 1);
  localparam logic [CntW-1:0] DataLoad = CntW'(DATA_WAIT - 1);

  seq_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cs_n_q, cs_n_d, wr_n_q, wr_n_d, a0_q, a0_d;
  logic [7:0]        d_q, d_d, data_q, data_d;
  logic              ovf_q;
  logic              en, push, pop, last;
  wr_entry_t         head;
  logic              not_full;
  logic [$clog2(DEPTH):0] level;

  assign en   = ~i_phiM_PCEN_n;
  assign push = i_WR_VALID & not_full;
  assign last = (cnt_q == '0);

  ikaopll_wrqueue_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i      (i_EMUCLK),
    .rst_i      (i_RST),
    .push_i     (push),
    .wdata_i    ('{reg_addr: i_WR_REG, data: i_WR_DATA}),
    .pop_i      (pop),
    .rdata_o    (head),
    .level_o    (level),
    .not_full_o (not_full)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    a0_d    = a0_q;
    d_d     = d_q;
    data_d  = data_q;
    pop     = 1'b0;
    if (en) begin
      if (state_q != StIdle) cnt_d = cnt_q - CntW'(1);
      case (state_q)
        StIdle: begin
          if (level != '0) begin
            pop     = 1'b1;
            data_d  = head.data;
            a0_d    = 1'b0;
            d_d     = head.reg_addr;
            cs_n_d  = 1'b0;
            wr_n_d  = 1'b0;
            cnt_d   = StbLoad;
            state_d = StAstb;
          end
        end
        StAstb: if (last) begin
          cs_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          cnt_d   = AddrLoad;
          state_d = StAwait;
        end
        StAwait: if (last) begin
          a0_d    = 1'b1;
          d_d     = data_q;
          cs_n_d  = 1'b0;
          wr_n_d  = 1'b0;
          cnt_d   = StbLoad;
          state_d = StDstb;
        end
        StDstb: if (last) begin
          cs_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          cnt_d   = DataLoad;
          state_d = StDwait;
        end
        StDwait: if (last) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
        default: begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      a0_q    <= 1'b0;
      d_q     <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      a0_q    <= a0_d;
      d_q     <= d_d;
      data_q  <= data_d;
      if (i_WR_VALID && !not_full) ovf_q <= 1'b1;
    end
  end

  assign o_CS_n     = cs_n_q;
  assign o_WR_n     = wr_n_q;
  assign o_A0       = a0_q;
  assign o_D        = d_q;
  assign o_LEVEL    = level;
  assign o_WR_READY = not_full;
  assign o_OVF      = ovf_q;
  assign o_BUSY     = (level != '0) | (state_q != StIdle);

endmodule

// File: tb/tb_ikaopll_wrqueue.sv
// Randomized and directed bench for ikaopll_wrqueue against a phase-count reference model.
module tb_ikaopll_wrqueue;

  localparam int Depth    = 16;
  localparam int StbLen   = 4;
  localparam int AddrWait = 12;
  localparam int DataWait = 84;
  localparam int DStart   = StbLen + AddrWait;
  localparam int DEnd     = DStart + StbLen;
  localparam int Total    = DEnd + DataWait;

  logic       clk = 1'b0;
  logic       i_RST = 1'b0, i_phiM_PCEN_n = 1'b1, i_WR_VALID = 1'b0;
  logic [7:0] i_WR_REG = '0, i_WR_DATA = '0;
  logic       o_WR_READY, o_CS_n, o_WR_n, o_A0, o_BUSY, o_OVF;
  logic [7:0] o_D;
  logic [4:0] o_LEVEL;

  always #5 clk = ~clk;

  ikaopll_wrqueue dut (
    .i_EMUCLK      (clk),
    .i_RST         (i_RST),
    .i_phiM_PCEN_n (i_phiM_PCEN_n),
    .i_WR_VALID    (i_WR_VALID),
    .o_WR_READY    (o_WR_READY),
    .i_WR_REG      (i_WR_REG),
    .i_WR_DATA     (i_WR_DATA),
    .o_CS_n        (o_CS_n),
    .o_WR_n        (o_WR_n),
    .o_A0          (o_A0),
    .o_D           (o_D),
    .o_LEVEL       (o_LEVEL),
    .o_BUSY        (o_BUSY),
    .o_OVF         (o_OVF)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of pending pairs plus the number of enables since the last pop.
  logic [15:0] mq[$];
  int          m_phase = -1;
  bit          m_a0 = 0, m_ovf = 0, m_ready = 1;
  logic [7:0]  m_d = '0, m_data = '0;

  int en_cnt = 0, last_start = -1, n_starts = 0;
  bit track_int = 0, prev_cs = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit en, input bit vld, input logic [7:0] r,
                            input logic [7:0] dt, input bit rst);
    bit pop, push;
    logic [15:0] e;
    if (rst) begin
      mq.delete();
      m_phase = -1; m_a0 = 0; m_d = '0; m_ovf = 0; m_ready = 1;
      return;
    end
    pop  = en && (m_phase < 0) && (mq.size() > 0);
    push = vld && m_ready;
    if (vld && !m_ready) m_ovf = 1;
    if (en && m_phase >= 0) begin
      m_phase++;
      if (m_phase == Total) m_phase = -1;
      else if (m_phase == DStart) begin m_a0 = 1; m_d = m_data; end
    end
    if (pop) begin
      e = mq.pop_front();
      m_phase = 0; m_a0 = 0; m_d = e[15:8]; m_data = e[7:0];
    end
    if (push) mq.push_back({r, dt});
    m_ready = (mq.size() < Depth);
  endtask

  function automatic bit m_strobe_low();
    return (m_phase >= 0 && m_phase < StbLen) || (m_phase >= DStart && m_phase < DEnd);
  endfunction

  task automatic compare_all();
    check("cs_n",  o_CS_n, !m_strobe_low());
    check("wr_n",  o_WR_n, !m_strobe_low());
    check("a0",    o_A0, m_a0);
    check("d",     o_D, m_d);
    check("level", o_LEVEL, mq.size());
    check("ready", o_WR_READY, m_ready);
    check("busy",  o_BUSY, (mq.size() > 0) || (m_phase >= 0));
    check("ovf",   o_OVF, m_ovf);
  endtask

  task automatic tick(input bit en, input bit vld, input logic [7:0] r,
                      input logic [7:0] dt, input bit rst);
    i_phiM_PCEN_n = ~en; i_WR_VALID = vld; i_WR_REG = r; i_WR_DATA = dt; i_RST = rst;
    @(posedge clk);
    model_step(en, vld, r, dt, rst);
    if (en && !rst) en_cnt++;
    @(negedge clk);
    compare_all();
    if (track_int && prev_cs && !o_CS_n && !o_A0) begin
      if (last_start >= 0) check("astb_interval", en_cnt - last_start, Total + 1);
      last_start = en_cnt;
      n_starts++;
    end
    prev_cs = o_CS_n;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) tick(en, 0, '0, '0, 0);
  endtask

  initial begin
    int guard;
    // Reset state
    tick(0, 0, '0, '0, 1);
    check("rst_cs_n", o_CS_n, 1); check("rst_a0", o_A0, 0);
    check("rst_d", o_D, 0); check("rst_ready", o_WR_READY, 1);
    check("rst_level", o_LEVEL, 0); check("rst_busy", o_BUSY, 0);

    // Single write, enable every 4th clock
    for (int i = 0; i < 110 * 4; i++) tick((i % 4) == 3, i == 0, 8'h10, 8'h55, 0);
    check("single_busy_end", o_BUSY, 0);
    check("single_a0_held", o_A0, 1);
    check("single_d_held", o_D, 8'h55);

    // Back-to-back: three pushes with enable low, then continuous enables
    for (int i = 0; i < 3; i++) tick(0, 1, 8'h20 + 8'(i), 8'hA0 + 8'(i), 0);
    check("b2b_level3", o_LEVEL, 3);
    track_int = 1; last_start = -1; n_starts = 0;
    idle(3 * (Total + 1) + 10, 1);
    track_int = 0;
    check("b2b_starts", n_starts, 3);
    check("b2b_last_data", o_D, 8'hA2);

    // Full: 17 pushes with enable held low
    for (int i = 0; i < Depth + 1; i++) tick(0, 1, 8'($urandom), 8'($urandom), 0);
    check("full_ready", o_WR_READY, 0);
    check("full_ovf", o_OVF, 1);
    check("full_level", o_LEVEL, Depth);
    idle(Depth * (Total + 1) + 10, 1);
    tick(0, 0, '0, '0, 1);
    check("ovf_cleared", o_OVF, 0);

    // Simultaneous push and pop at level 1
    tick(0, 1, 8'h30, 8'h31, 0);
    tick(1, 1, 8'h32, 8'h33, 0);
    check("simul_level", o_LEVEL, 1);
    idle(2 * (Total + 1) + 10, 1);

    // Reset during the data strobe
    tick(0, 1, 8'h40, 8'h41, 0);
    guard = 0;
    while (m_phase != DStart + 1 && guard < 500) begin tick(1, 0, '0, '0, 0); guard++; end
    check("dstb_reached", m_phase, DStart + 1);
    check("dstb_low", o_CS_n, 0);
    tick(1, 0, '0, '0, 1);
    check("mid_rst_cs_n", o_CS_n, 1); check("mid_rst_wr_n", o_WR_n, 1);
    check("mid_rst_a0", o_A0, 0); check("mid_rst_d", o_D, 0);
    check("mid_rst_level", o_LEVEL, 0); check("mid_rst_ovf", o_OVF, 0);
    idle(300, 1);

    // Enable gated off mid-AWAIT
    tick(0, 1, 8'h50, 8'h51, 0);
    guard = 0;
    while (m_phase != 8 && guard < 500) begin tick(1, 0, '0, '0, 0); guard++; end
    check("await_reached", m_phase, 8);
    idle(1000, 0);
    check("frozen_a0", o_A0, 0); check("frozen_d", o_D, 8'h50);
    idle(Total + 20, 1);

    // Randomized traffic
    for (int i = 0; i < 20000; i++)
      tick(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 8'($urandom), 8'($urandom),
           $urandom_range(0, 999) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
